// File: rtl/copy_responder.sv
// Ring copy responder: absorbs requests addressed to this core, sums their payload words,
// and answers each one with a header/payload reply once a token has been claimed.
module copy_responder #(
   parameter logic [3:0] REPLY_TYPE = 4'd1,
   parameter int         QDEPTH     = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  whichCore,
   input  logic [31:0] RingIn,
   input  logic [3:0]  SlotTypeIn,
   input  logic [3:0]  SrcDestIn,
   output logic [31:0] respRingOut,
   output logic [3:0]  respSlotTypeOut,
   output logic [3:0]  respSrcDestOut,
   output logic        respDriveRing,
   output logic        respWaiting,
   output logic        busy,
   output logic        overflow
);

   localparam logic [3:0] SLOT_TOKEN   = 4'd1;
   localparam logic [3:0] SLOT_NULL    = 4'd7;
   localparam logic [3:0] SLOT_MESSAGE = 4'd8;

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(QDEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TOKEN,
      S_WAIT_N,
      S_SEND_HDR,
      S_SEND_PAY
   } state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic [7:0]    r_burst;
   logic [7:0]    w_nextBurst;

   logic [5:0]    r_rxLen;
   logic [3:0]    r_src;
   logic [31:0]   r_sum;

   logic [35:0]   r_mem [QDEPTH];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;

   logic          w_addressed;
   logic          w_isHeader;
   logic          w_complete;
   logic [31:0]   w_sumNext;
   logic [35:0]   w_pushData;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_drop;
   logic          w_tokenSeen;
   logic [35:0]   w_head;
   logic [3:0]    w_headSrc;
   logic [31:0]   w_headSum;

   assign w_addressed = (SlotTypeIn == SLOT_MESSAGE) && (SrcDestIn == whichCore);
   assign w_isHeader  = w_addressed && (r_rxLen == 6'd0);
   assign w_sumNext   = r_sum + RingIn;
   assign w_complete  = (w_isHeader && (RingIn[5:0] == 6'd0)) || (r_rxLen == 6'd1);
   assign w_pushData  = w_isHeader ? {RingIn[13:10], 32'd0} : {r_src, w_sumNext};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rxLen <= 6'd0;
         r_src   <= 4'd0;
         r_sum   <= 32'd0;
      end else if (r_rxLen != 6'd0) begin
         r_sum   <= w_sumNext;
         r_rxLen <= r_rxLen - 6'd1;
      end else if (w_isHeader) begin
         r_src   <= RingIn[13:10];
         r_rxLen <= RingIn[5:0];
         r_sum   <= 32'd0;
      end
   end

   // A pop frees the slot on the same edge, so a full queue still accepts a completing request then.
   assign w_full  = (r_count == FULL_COUNT);
   assign w_empty = (r_count == '0);
   assign w_pop   = (r_state == S_SEND_PAY);
   assign w_push  = w_complete && (!w_full || w_pop);
   assign w_drop  = w_complete && w_full && !w_pop;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wrPtr  <= '0;
         r_rdPtr  <= '0;
         r_count  <= '0;
         overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
         if (w_drop) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= w_pushData;
      end
   end

   assign w_head    = r_mem[r_rdPtr];
   assign w_headSrc = w_head[35:32];
   assign w_headSum = w_head[31:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_burst <= 8'd0;
      end else begin
         r_state <= w_nextState;
         r_burst <= w_nextBurst;
      end
   end

   assign w_tokenSeen = (r_state == S_WAIT_TOKEN) && (SlotTypeIn == SLOT_TOKEN);

   always_comb begin
      w_nextState = r_state;
      w_nextBurst = r_burst;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_nextState = S_WAIT_TOKEN;
            end
         end
         S_WAIT_TOKEN: begin
            if (w_tokenSeen) begin
               if (RingIn[7:0] == 8'd0) begin
                  w_nextState = S_SEND_HDR;
               end else begin
                  w_nextBurst = RingIn[7:0];
                  w_nextState = S_WAIT_N;
               end
            end
         end
         S_WAIT_N: begin
            w_nextBurst = r_burst - 8'd1;
            if (r_burst == 8'd1) begin
               w_nextState = S_SEND_HDR;
            end
         end
         S_SEND_HDR: begin
            w_nextState = S_SEND_PAY;
         end
         S_SEND_PAY: begin
            w_nextState = S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Null conversion is gated by reset because it is the only drive case not tied to FSM state.
   always_comb begin
      respRingOut     = RingIn;
      respSlotTypeOut = SlotTypeIn;
      respSrcDestOut  = SrcDestIn;
      respDriveRing   = 1'b0;
      if (r_state == S_SEND_HDR) begin
         respRingOut     = {18'd0, whichCore, REPLY_TYPE, 6'd1};
         respSlotTypeOut = SLOT_MESSAGE;
         respSrcDestOut  = w_headSrc;
         respDriveRing   = 1'b1;
      end else if (r_state == S_SEND_PAY) begin
         respRingOut     = w_headSum;
         respSlotTypeOut = SLOT_MESSAGE;
         respSrcDestOut  = w_headSrc;
         respDriveRing   = 1'b1;
      end else if (w_tokenSeen) begin
         respRingOut     = RingIn + 32'd2;
         respDriveRing   = 1'b1;
      end else if (w_addressed && reset) begin
         respSlotTypeOut = SLOT_NULL;
         respDriveRing   = 1'b1;
      end
   end

   assign respWaiting = (r_state == S_WAIT_TOKEN);
   assign busy        = (r_rxLen != 6'd0) || !w_empty || (r_state != S_IDLE);

endmodule
